spi_slave_param: RTL

SPI_SLAVE_PARAM -- requirements
Module: spi_slave_param

---
 rtl/spi_slave_param.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/spi_slave_param.sv
// rtl/spi_slave_param.sv - parameterised SPI slave with one-entry TX holding register
//
// Ports:
//   clk         in   system clock, all logic on rising edge
//   rst         in   asynchronous active-low reset
//   SCK         in   SPI clock (asynchronous to clk)
//   SSEL        in   SPI slave select, active-low (asynchronous to clk)
//   MOSI        in   SPI master-out data (asynchronous to clk)
//   MISO        out  SPI slave-out data, TX shift register output bit
//   miso_oe     out  MISO output enable, high while the slave is selected
//   tx_data     in   [DATA_W] next word to transmit
//   tx_valid    in   tx_data valid
//   tx_ready    out  holding register empty, tx_data can be accepted
//   rx_data     out  [DATA_W] last complete received word
//   rx_valid    out  one-cycle pulse, rx_data updated
//   tx_underrun out  one-cycle pulse, IDLE_WORD loaded for lack of data
//   frame_end   out  one-cycle pulse on SSEL deassertion
`timescale 1ns/1ps
module spi_slave_param #(
  parameter int                DATA_W    = 8,
  parameter bit                CPOL      = 1'b0,
  parameter bit                CPHA      = 1'b0,
  parameter bit                LSB_FIRST = 1'b0,
  parameter logic [DATA_W-1:0] IDLE_WORD = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SCK,
  input  logic              SSEL,
  input  logic              MOSI,
  output logic              MISO,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun,
  output logic              frame_end
);

  localparam int               CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;
  state_t state_q, state_d;

  logic [2:0]        sck_sync;
  logic [2:0]        ssel_sync;
  logic [1:0]        mosi_sync;
  logic [CNT_W-1:0]  bit_cnt;
  logic              wrapped;
  logic [DATA_W-1:0] rx_shift;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] hold;
  logic              hold_full;

  logic sck_rise, sck_fall, ssel_fall, ssel_rise, mosi_bit;
  logic lead_edge, trail_edge;
  logic enter, leave, in_frame, sample_edge, shift_edge, load;
  logic [DATA_W-1:0] rx_next;
  logic [DATA_W-1:0] tx_shifted;

  // SSEL resets to "deselected" so that reset release never looks like a frame start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sck_sync  <= '0;
      ssel_sync <= '1;
      mosi_sync <= '0;
    end else begin
      sck_sync  <= {sck_sync[1:0], SCK};
      ssel_sync <= {ssel_sync[1:0], SSEL};
      mosi_sync <= {mosi_sync[0], MOSI};
    end
  end

  assign sck_rise   = sck_sync[1] & ~sck_sync[2];
  assign sck_fall   = ~sck_sync[1] & sck_sync[2];
  assign ssel_fall  = ~ssel_sync[1] & ssel_sync[2];
  assign ssel_rise  = ssel_sync[1] & ~ssel_sync[2];
  assign mosi_bit   = mosi_sync[1];
  assign lead_edge  = CPOL ? sck_fall : sck_rise;
  assign trail_edge = CPOL ? sck_rise : sck_fall;

  assign rx_next    = LSB_FIRST ? {mosi_bit, rx_shift[DATA_W-1:1]}
                                : {rx_shift[DATA_W-2:0], mosi_bit};
  assign tx_shifted = LSB_FIRST ? {1'b0, tx_shift[DATA_W-1:1]}
                                : {tx_shift[DATA_W-2:0], 1'b0};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    enter       = 1'b0;
    leave       = 1'b0;
    in_frame    = 1'b0;
    sample_edge = 1'b0;
    shift_edge  = 1'b0;
    load        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ssel_fall) begin
          state_d = S_ACTIVE;
          enter   = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (ssel_rise) begin
          state_d = S_IDLE;
          leave   = 1'b1;
        end else begin
          in_frame = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    sample_edge = in_frame & (CPHA ? trail_edge : lead_edge);
    shift_edge  = in_frame & (CPHA ? lead_edge : trail_edge);
    // CPHA=0 presents the first bit before any clock, so the first word is
    // loaded on selection; later words load on the shift edge after a wrap.
    if (CPHA) load = shift_edge & (bit_cnt == '0);
    else      load = enter | (shift_edge & (bit_cnt == '0) & wrapped);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt     <= '0;
      wrapped     <= 1'b0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      hold        <= '0;
      hold_full   <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_end   <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_end   <= 1'b0;

      if (leave) begin
        bit_cnt   <= '0;
        wrapped   <= 1'b0;
        rx_shift  <= '0;
        frame_end <= 1'b1;
      end else if (sample_edge) begin
        rx_shift <= rx_next;
        if (bit_cnt == LAST_BIT) begin
          bit_cnt  <= '0;
          wrapped  <= 1'b1;
          rx_data  <= rx_next;
          rx_valid <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
      end

      if (load) begin
        if (hold_full) begin
          tx_shift  <= hold;
          hold_full <= 1'b0;
        end else begin
          tx_shift    <= IDLE_WORD;
          tx_underrun <= 1'b1;
        end
      end else if (shift_edge) begin
        tx_shift <= tx_shifted;
      end

      // Only possible while hold is empty, so it never races the load above;
      // a word accepted during an underrun load waits in hold for the next load.
      if (tx_valid && tx_ready) begin
        hold      <= tx_data;
        hold_full <= 1'b1;
      end
    end
  end

  assign tx_ready = ~hold_full;
  assign miso_oe  = (state_q == S_ACTIVE);
  assign MISO     = LSB_FIRST ? tx_shift[0] : tx_shift[DATA_W-1];

endmodule
